// File: rtl/dmem_mmio.sv
// Data-side memory for the MEM stage: word RAM plus an MMIO page with a TX byte FIFO,
// status register and an optional free-running cycle counter (enable with DMEM_CYCLE_COUNTER_EN).
module dmem_mmio #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dmemread,
  input  logic                  dmemwrite,
  input  logic [31:0]           dadr,
  input  logic [DATA_WIDTH-1:0] dmemwd,
  output logic [DATA_WIDTH-1:0] dmemrd,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  // Address decode
  logic          mmio_sel;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;

  assign mmio_sel = (dadr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = dadr[3:2];
  assign ram_idx  = dadr[AW+1:2];

  // Word RAM, no reset; reads see the pre-write contents in a store cycle
  logic [DATA_WIDTH-1:0] ram [MEM_WORDS];
  logic                  ram_we;

  assign ram_we = dmemwrite && !mmio_sel;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= dmemwd;
    end
  end

  // TX FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          overflow, overflow_nxt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_clr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign push_req   = dmemwrite && mmio_sel && (mmio_off == OFF_TXDATA);
  assign pop        = !fifo_empty && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = dmemwrite && mmio_sel && (mmio_off == OFF_STATUS) && dmemwd[2];

  // FIFO next-state; a new overflow takes priority over a clear in the same cycle
  always_comb begin
    rd_ptr_nxt   = rd_ptr;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count;
    overflow_nxt = overflow;
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    if (ovf_clr) begin
      overflow_nxt = 1'b0;
    end
    if (push_req && fifo_full && !pop) begin
      overflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by count alone
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= dmemwd[7:0];
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Cycle counter
  logic [31:0] cycle_rd;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic        cycle_wr;

  assign cycle_wr = dmemwrite && mmio_sel && (mmio_off == OFF_CYCLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cycle_wr) begin
      cycle_cnt <= 32'(dmemwd);
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = 32'h0;
`endif

  // MMIO read mux; registers are 32 bit and resized to the data bus
  logic [31:0] status_word;
  logic [31:0] mmio_rd;

  assign status_word = {16'h0, 8'(count), 5'h0, overflow, fifo_full, fifo_empty};

  always_comb begin
    mmio_rd = 32'h0;
    case (mmio_off)
      OFF_STATUS: mmio_rd = status_word;
      OFF_CYCLE:  mmio_rd = cycle_rd;
      default:    mmio_rd = 32'h0;
    endcase
  end

  assign dmemrd = mmio_sel ? DATA_WIDTH'(mmio_rd) : ram[ram_idx];

  // Reads are always live, so dmemread and the byte-offset bits carry no function here
  logic unused_bits;
  assign unused_bits = ^{dmemread, dadr[1:0], dmemwd};

endmodule
